// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the trap sequencer: FSM states, event kinds and interrupt causes.
package trap_ctrl_pkg;

    typedef logic [1:0] state_t;
    localparam state_t StIdle     = 2'd0;
    localparam state_t StDrain    = 2'd1;
    localparam state_t StUpdate   = 2'd2;
    localparam state_t StRedirect = 2'd3;

    typedef logic kind_t;
    localparam kind_t KindTrap = 1'b0;
    localparam kind_t KindMret = 1'b1;

    localparam int unsigned CauseMei = 11;
    localparam int unsigned CauseMsi = 3;
    localparam int unsigned CauseMti = 7;

endpackage

// File: rtl/trap_ctrl_prio.sv
// Fixed-priority pick of one event per trap sequence: exception, then mret, then interrupt.
module trap_prio
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned VIRTUAL_ADDR_LEN     = 32,
    parameter int unsigned EXCEPTION_CODE_WIDTH = 4
) (
    input  logic                            exc_valid,
    input  logic [VIRTUAL_ADDR_LEN-1:0]     exc_pc,
    input  logic [EXCEPTION_CODE_WIDTH-1:0] exc_cause,
    input  logic                            mret_valid,
    input  logic                            commit_ready,
    input  logic [VIRTUAL_ADDR_LEN-1:0]     commit_pc,
    input  logic                            eip,
    input  logic                            sip,
    input  logic                            tip,
    output logic                            ev_valid,
    output kind_t                           ev_kind,
    output logic [EXCEPTION_CODE_WIDTH-1:0] ev_cause,
    output logic                            ev_irq,
    output logic [VIRTUAL_ADDR_LEN-1:0]     ev_pc
);

    always_comb begin
        ev_valid = 1'b0;
        ev_kind  = KindTrap;
        ev_cause = '0;
        ev_irq   = 1'b0;
        ev_pc    = '0;
        if (exc_valid) begin
            ev_valid = 1'b1;
            ev_cause = exc_cause;
            ev_pc    = exc_pc;
        end else if (mret_valid) begin
            ev_valid = 1'b1;
            ev_kind  = KindMret;
        end else if (commit_ready && (eip || sip || tip)) begin
            ev_valid = 1'b1;
            ev_irq   = 1'b1;
            ev_pc    = commit_pc;
            if (eip) begin
                ev_cause = EXCEPTION_CODE_WIDTH'(CauseMei);
            end else if (sip) begin
                ev_cause = EXCEPTION_CODE_WIDTH'(CauseMsi);
            end else begin
                ev_cause = EXCEPTION_CODE_WIDTH'(CauseMti);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrate one event, flush and drain the pipe, strobe csr, redirect fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned VIRTUAL_ADDR_LEN     = 32,
    parameter int unsigned EXCEPTION_CODE_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            exc_valid,
    input  logic [VIRTUAL_ADDR_LEN-1:0]     exc_pc,
    input  logic [EXCEPTION_CODE_WIDTH-1:0] exc_cause,
    input  logic                            mret_valid,
    input  logic                            commit_ready,
    input  logic [VIRTUAL_ADDR_LEN-1:0]     commit_pc,
    input  logic                            eip,
    input  logic                            sip,
    input  logic                            tip,
    input  logic                            pipe_idle,
    input  logic [VIRTUAL_ADDR_LEN-1:0]     trap_vector,
    input  logic [VIRTUAL_ADDR_LEN-1:0]     mret_vector,
    output logic                            traped,
    output logic                            mret,
    output logic                            interupt,
    output logic [VIRTUAL_ADDR_LEN-1:0]     ecp,
    output logic [EXCEPTION_CODE_WIDTH-1:0] trap_cause,
    output logic                            flush,
    output logic                            redirect_valid,
    output logic [VIRTUAL_ADDR_LEN-1:0]     redirect_pc,
    input  logic                            redirect_ready,
    output logic                            busy
);

    logic                            ev_valid;
    kind_t                           ev_kind;
    logic [EXCEPTION_CODE_WIDTH-1:0] ev_cause;
    logic                            ev_irq;
    logic [VIRTUAL_ADDR_LEN-1:0]     ev_pc;

    trap_prio #(
        .VIRTUAL_ADDR_LEN    (VIRTUAL_ADDR_LEN),
        .EXCEPTION_CODE_WIDTH(EXCEPTION_CODE_WIDTH)
    ) u_prio (
        .exc_valid   (exc_valid),
        .exc_pc      (exc_pc),
        .exc_cause   (exc_cause),
        .mret_valid  (mret_valid),
        .commit_ready(commit_ready),
        .commit_pc   (commit_pc),
        .eip         (eip),
        .sip         (sip),
        .tip         (tip),
        .ev_valid    (ev_valid),
        .ev_kind     (ev_kind),
        .ev_cause    (ev_cause),
        .ev_irq      (ev_irq),
        .ev_pc       (ev_pc)
    );

    state_t                          state_q, state_d;
    kind_t                           kind_q, kind_d;
    logic [VIRTUAL_ADDR_LEN-1:0]     ecp_q, ecp_d;
    logic [EXCEPTION_CODE_WIDTH-1:0] cause_q, cause_d;
    logic                            irq_q, irq_d;
    logic                            flush_q, flush_d;
    logic                            traped_q, traped_d;
    logic                            mret_q, mret_d;
    logic                            rvalid_q, rvalid_d;
    logic                            busy_q, busy_d;
    logic                            take;

    assign take = (state_q == StIdle) && ev_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (ev_valid) state_d = StDrain;
            StDrain:    if (pipe_idle) state_d = StUpdate;
            StUpdate:   state_d = StRedirect;
            StRedirect: if (rvalid_q && redirect_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // An mret only records its kind; the trap payload keeps its last latched value.
    always_comb begin
        kind_d  = kind_q;
        ecp_d   = ecp_q;
        cause_d = cause_q;
        irq_d   = irq_q;
        if (take) begin
            kind_d = ev_kind;
            if (ev_kind == KindTrap) begin
                ecp_d   = ev_pc;
                cause_d = ev_cause;
                irq_d   = ev_irq;
            end
        end
    end

    // Strobes are derived from the next state so they appear as registered outputs.
    always_comb begin
        flush_d  = take;
        traped_d = (state_d == StUpdate) && (kind_d == KindTrap);
        mret_d   = (state_d == StUpdate) && (kind_d == KindMret);
        rvalid_d = (state_d == StRedirect);
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            kind_q   <= KindTrap;
            ecp_q    <= '0;
            cause_q  <= '0;
            irq_q    <= 1'b0;
            flush_q  <= 1'b0;
            traped_q <= 1'b0;
            mret_q   <= 1'b0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            ecp_q    <= ecp_d;
            cause_q  <= cause_d;
            irq_q    <= irq_d;
            flush_q  <= flush_d;
            traped_q <= traped_d;
            mret_q   <= mret_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
        end
    end

    assign traped         = traped_q;
    assign mret           = mret_q;
    assign interupt       = irq_q;
    assign ecp            = ecp_q;
    assign trap_cause     = cause_q;
    assign flush          = flush_q;
    assign redirect_valid = rvalid_q;
    assign busy           = busy_q;

    // Vectors come live from csr; gated so the port reads zero outside REDIRECT.
    assign redirect_pc = !rvalid_q ? '0 : (kind_q == KindMret) ? mret_vector : trap_vector;

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer that sits between commit, the `csr` block and fetch. It picks one event per trap sequence, choosing between a committing exception, a committing `mret` and a pending interrupt. It then flushes the pipeline, waits for drain, pulses the CSR update strobes and hands the redirect PC to fetch over a valid/ready handshake. The block owns every `traped`/`mret`/`interupt`/`ecp`/`trap_cause` input of `csr`.

## Interface
Parameters:
- `VIRTUAL_ADDR_LEN`, 32, PC/vector width
- `EXCEPTION_CODE_WIDTH`, 4, cause code width

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `exc_valid`  in  1  committing instruction raised an exception
- `exc_pc`  in  VIRTUAL_ADDR_LEN  PC of the excepting instruction
- `exc_cause`  in  EXCEPTION_CODE_WIDTH  exception code
- `mret_valid`  in  1  committing instruction is `mret`
- `commit_ready`  in  1  commit is at an instruction boundary (interrupt may be taken)
- `commit_pc`  in  VIRTUAL_ADDR_LEN  PC of the next instruction to commit
- `eip`, `sip`, `tip`  in  1 each  gated pending interrupts from `csr`
- `pipe_idle`  in  1  no outstanding memory or in-flight operations
- `trap_vector`, `mret_vector`  in  VIRTUAL_ADDR_LEN  from `csr`
- `traped`, `mret`, `interupt`  out  1  to `csr`
- `ecp`  out  VIRTUAL_ADDR_LEN  to `csr`
- `trap_cause`  out  EXCEPTION_CODE_WIDTH  to `csr`
- `flush`  out  1  one-cycle pipeline flush pulse
- `redirect_valid`  out  1  to fetch
- `redirect_pc`  out  VIRTUAL_ADDR_LEN  to fetch
- `redirect_ready`  in  1  from fetch
- `busy`  out  1  stall commit; high whenever state != IDLE

## Operation
- States: IDLE, DRAIN, UPDATE, REDIRECT.
- IDLE event priority is fixed, highest first:
  - `exc_valid`: latch `exc_pc` and `exc_cause`, interrupt flag 0.
  - `mret_valid`: latch the mret kind.
  - interrupt, only taken when `commit_ready=1`: choose `eip` (cause 11), else `sip` (cause 3), else `tip` (cause 7). Latch `commit_pc` and the cause, interrupt flag 1.
- Any event moves IDLE→DRAIN. With no event the FSM stays in IDLE.
- DRAIN: `flush=1` on the first DRAIN cycle only. Stay until `pipe_idle=1`, then go to UPDATE.
- UPDATE lasts exactly one cycle.
  - Trap: `traped=1`, with `ecp`, `trap_cause` and `interupt` driven from the latched values.
  - mret: `mret=1`.
  - Then go to REDIRECT.
- REDIRECT: `redirect_valid=1`.
  - `redirect_pc` is `trap_vector` for a trap and `mret_vector` for an mret, sampled live from `csr`.
  - On `redirect_valid && redirect_ready`, go to IDLE.
- Inputs arriving while busy are ignored. Commit is stalled by `busy`, and any interrupt still pending re-arbitrates in IDLE.
- An interrupt that deasserts after being latched is still taken.
- `ecp`, `trap_cause` and `interupt` hold their latched values outside UPDATE. `csr` ignores them unless `traped=1`.
- Reset (asynchronous, any state): state IDLE; every output 0; latched PC and cause 0.

## Timing
- Event sampled at cycle 0 (IDLE). Cycle 1: DRAIN with `flush=1`. The earliest UPDATE is cycle 2 (when `pipe_idle=1` at cycle 1), and the earliest `redirect_valid` is cycle 3.
- Minimum turnaround is 4 cycles. IDLE is re-entered in the cycle after the handshake.
- All outputs are registered from state and latches, except `redirect_pc`, which muxes the live vector.
- `redirect_valid` must stay asserted until accepted.
- The redirect payload must stay stable while `redirect_valid=1`.

## Structure
- Shared package holds:
  - the state enum;
  - the cause constants MEI=11, MSI=3, MTI=7;
  - the kind encoding {TRAP, MRET}.
- One sub-module, `trap_prio`: a combinational priority encoder producing event valid, kind, cause, interrupt flag and PC.
- Main body is the FSM plus the latches. Target is 150–250 RTL lines.

## Test plan
- `exc_valid=1`, `exc_pc=0x100`, `exc_cause=2`, `pipe_idle=1`, `redirect_ready=1`:
  - cycle 1: `flush=1`;
  - cycle 2: `traped=1`, `ecp=0x100`, `trap_cause=2`, `interupt=0`;
  - cycle 3: `redirect_pc=trap_vector`;
  - cycle 4: IDLE.
- `exc_valid`, `mret_valid`, `eip` and `commit_ready` all high together → exception is taken. After return to IDLE with `eip` still high → interrupt taken, `trap_cause=11`, `ecp=commit_pc`, `interupt=1`.
- `sip=tip=1`, `commit_ready=1` → `trap_cause=3`. With `commit_ready=0` → stays in IDLE, `busy=0`.
- `mret_valid=1`, `pipe_idle` held low for 5 cycles → DRAIN persists and `flush` fires once only. Then `mret=1` for one cycle, `redirect_pc=mret_vector`, `traped=0`.
- `redirect_ready` low for 3 cycles → `redirect_valid` and `redirect_pc` stay stable; IDLE follows the cycle after ready rises.
- `reset_n` pulsed low during DRAIN → all outputs 0 immediately, IDLE after release, no `traped` pulse.
